// File: rtl/ex_div_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_defs (package)
//  Description : Shared definitions for the EX-stage divider: operation
//                encodings, FSM state encoding, special-case result constants
//                and a conditional two's-complement helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_defs;

    // Divider operation select (OP[1] picks remainder, OP[0] picks unsigned)
    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    // Divider sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } div_state_e;

    localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN    = 32'h8000_0000;

    // Two's-complement negate when neg is set, pass-through otherwise.
    function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ex_div_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : ex_div_unit_if
//  Description : Request/response bundle between the EX stage and the divider.
//                master : START, FLUSH, OP, OPERAND1, OPERAND2 out;
//                         BUSY, DONE, RESULT in
//                slave  : the reverse
//  Revision    : 1.0 - initial release
// ============================================================================
interface ex_div_unit_if #(
    parameter int XLEN = 32
);
    logic            START;
    logic            FLUSH;
    logic [1:0]      OP;
    logic [XLEN-1:0] OPERAND1;
    logic [XLEN-1:0] OPERAND2;
    logic            BUSY;
    logic            DONE;
    logic [XLEN-1:0] RESULT;

    modport master (
        output START, FLUSH, OP, OPERAND1, OPERAND2,
        input  BUSY, DONE, RESULT
    );

    modport slave (
        input  START, FLUSH, OP, OPERAND1, OPERAND2,
        output BUSY, DONE, RESULT
    );
endinterface
`default_nettype wire

// File: rtl/ex_div_unit_div_step.sv
`default_nettype none
// ============================================================================
//  Module      : div_step
//  Description : One combinational restoring-division iteration. Shifts
//                {rem, quo} left by one, trial-subtracts the divisor and
//                commits the difference with quotient bit 1 when it does not
//                go negative.
//  Ports       : rem_i/quo_i  - current partial remainder / quotient
//                dvsr_i       - divisor magnitude
//                rem_o/quo_o  - values after this iteration
//  Revision    : 1.0 - initial release
// ============================================================================
module div_step #(
    parameter int XLEN = 32
) (
    input  wire logic [XLEN-1:0] rem_i,
    input  wire logic [XLEN-1:0] quo_i,
    input  wire logic [XLEN-1:0] dvsr_i,
    output logic      [XLEN-1:0] rem_o,
    output logic      [XLEN-1:0] quo_o
);

    // Shifted remainder needs one extra bit before the trial subtract.
    logic [XLEN:0] w_shift;
    logic          w_ge;

    assign w_shift = {rem_i, quo_i[XLEN-1]};
    assign w_ge    = (w_shift >= {1'b0, dvsr_i});

    always_comb begin
        rem_o = w_shift[XLEN-1:0];
        quo_o = {quo_i[XLEN-2:0], 1'b0};
        if (w_ge) begin
            // Difference is below the divisor, so it fits in XLEN bits.
            rem_o = w_shift[XLEN-1:0] - dvsr_i;
            quo_o = {quo_i[XLEN-2:0], 1'b1};
        end
    end

endmodule
`default_nettype wire

// File: rtl/ex_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : ex_div_unit
//  Description : Iterative radix-2 restoring divider for the RV32IM EX stage
//                (DIV, DIVU, REM, REMU). Magnitudes are divided over 32 RUN
//                cycles, signs are applied in FIX, and RESULT is registered
//                with a one-cycle DONE strobe. BUSY stalls the pipeline while
//                RUN/FIX are active.
//  Ports       : CLK, RESET (async, active-high)
//                div_if (slave): START, FLUSH, OP, OPERAND1, OPERAND2 in;
//                                BUSY, DONE, RESULT out
//  Options     : DIV_EARLY_OUT_EN - resolve divide-by-zero and signed
//                overflow at capture, DONE one cycle after START.
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_div_unit
    import cpu_defs::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  wire logic  CLK,
    input  wire logic  RESET,
    ex_div_unit_if.slave div_if
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

    div_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] dvsr_q;
    logic            sel_rem_q;
    logic            qsign_q;
    logic            rsign_q;
    logic            divz_q;
    logic            busy_q;
    logic            done_q;
    logic [XLEN-1:0] result_q;

    logic [XLEN-1:0] rem_d;
    logic [XLEN-1:0] quo_d;
    logic            w_signed;
    logic [XLEN-1:0] w_quo_fix;
    logic [XLEN-1:0] w_rem_fix;

    assign w_signed = ~div_if.OP[0];

    div_step #(
        .XLEN (XLEN)
    ) u_div_step (
        .rem_i  (rem_q),
        .quo_i  (quo_q),
        .dvsr_i (dvsr_q),
        .rem_o  (rem_d),
        .quo_o  (quo_d)
    );

    // A zero divisor yields all-ones quotient with no sign fix; its remainder
    // naturally equals the dividend once the dividend's sign is reapplied.
    assign w_quo_fix = divz_q ? quo_q : neg_if(quo_q, qsign_q);
    assign w_rem_fix = neg_if(rem_q, rsign_q);

`ifdef DIV_EARLY_OUT_EN
    logic            w_dz;
    logic            w_ovf;
    logic            w_early;
    logic [XLEN-1:0] w_early_res;

    assign w_dz    = (div_if.OPERAND2 == '0);
    assign w_ovf   = w_signed && (div_if.OPERAND1 == INT_MIN) && (div_if.OPERAND2 == '1);
    assign w_early = w_dz | w_ovf;

    always_comb begin
        w_early_res = div_if.OP[1] ? '0 : INT_MIN;
        if (w_dz) begin
            w_early_res = div_if.OP[1] ? div_if.OPERAND1 : DIV_ZERO_Q;
        end
    end
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            sel_rem_q <= 1'b0;
            qsign_q   <= 1'b0;
            rsign_q   <= 1'b0;
            divz_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
        end else begin
            done_q <= 1'b0;
            if (div_if.FLUSH) begin
                // Abort: RESULT is left untouched and no DONE is produced.
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    ST_IDLE, ST_DONE: begin
                        if (div_if.START) begin
                            sel_rem_q <= div_if.OP[1];
                            quo_q     <= neg_if(div_if.OPERAND1, w_signed & div_if.OPERAND1[XLEN-1]);
                            dvsr_q    <= neg_if(div_if.OPERAND2, w_signed & div_if.OPERAND2[XLEN-1]);
                            qsign_q   <= w_signed & (div_if.OPERAND1[XLEN-1] ^ div_if.OPERAND2[XLEN-1]);
                            rsign_q   <= w_signed & div_if.OPERAND1[XLEN-1];
                            divz_q    <= (div_if.OPERAND2 == '0);
                            rem_q     <= '0;
                            cnt_q     <= '0;
`ifdef DIV_EARLY_OUT_EN
                            if (w_early) begin
                                state_q  <= ST_DONE;
                                busy_q   <= 1'b0;
                                done_q   <= 1'b1;
                                result_q <= w_early_res;
                            end else begin
                                state_q <= ST_RUN;
                                busy_q  <= 1'b1;
                            end
`else
                            state_q <= ST_RUN;
                            busy_q  <= 1'b1;
`endif
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                    ST_RUN: begin
                        rem_q <= rem_d;
                        quo_q <= quo_d;
                        // Wraps back to zero on the final iteration.
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_CNT) begin
                            state_q <= ST_FIX;
                        end
                    end
                    ST_FIX: begin
                        result_q <= sel_rem_q ? w_rem_fix : w_quo_fix;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= ST_DONE;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign div_if.BUSY   = busy_q;
    assign div_if.DONE   = done_q;
    assign div_if.RESULT = result_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ex_div_unit
//  Description : Self-checking bench for ex_div_unit. Directed operations push
//                their expected RESULT and DONE cycle into a queue; a monitor
//                pops and compares on every DONE strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_div_unit;

    localparam int LAT = 33;
`ifdef DIV_EARLY_OUT_EN
    localparam int LAT_SPECIAL = 0;
`else
    localparam int LAT_SPECIAL = 33;
`endif

    typedef struct {
        logic [31:0] res;
        int          cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_pass;
    int   n_total;
    exp_t sb[$];

    ex_div_unit_if #(.XLEN(32)) dif();

    ex_div_unit dut (
        .CLK    (clk),
        .RESET  (rst),
        .div_if (dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor
    always @(negedge clk) begin
        if (dif.DONE) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_done cycle=%0d result=%h required=no DONE", cyc, dif.RESULT);
            end else begin
                exp_t e;
                e = sb.pop_front();
                n_total++;
                if (dif.RESULT === e.res) n_pass++;
                else $display("FAIL result actual=%h required=%h", dif.RESULT, e.res);
                n_total++;
                if (cyc == e.cyc) n_pass++;
                else $display("FAIL done_cycle actual=%0d required=%0d", cyc, e.cyc);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h", nm, act, exp);
    endtask

    task automatic drive_now(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                             input bit push, input logic [31:0] e, input int lat);
        exp_t x;
        dif.START    = 1'b1;
        dif.OP       = op;
        dif.OPERAND1 = a;
        dif.OPERAND2 = b;
        if (push) begin
            x.res = e;
            x.cyc = cyc + 1 + lat;
            sb.push_back(x);
        end
    endtask

    task automatic go(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input bit push, input logic [31:0] e, input int lat);
        @(negedge clk);
        drive_now(op, a, b, push, e, lat);
        @(negedge clk);
        dif.START = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            n_total++;
            $display("FAIL timeout pending=%0d required=0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        n_pass       = 0;
        n_total      = 0;
        rst          = 1'b1;
        dif.START    = 1'b0;
        dif.FLUSH    = 1'b0;
        dif.OP       = 2'b00;
        dif.OPERAND1 = '0;
        dif.OPERAND2 = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy",   {31'd0, dif.BUSY}, 32'd0);
        chk("reset_done",   {31'd0, dif.DONE}, 32'd0);
        chk("reset_result", dif.RESULT,        32'd0);
        rst = 1'b0;

        // Basic unsigned and signed operations
        go(2'b01, 32'd100, 32'd7, 1, 32'd14, LAT);               wait_idle();
        go(2'b11, 32'd100, 32'd7, 1, 32'd2, LAT);                wait_idle();
        go(2'b00, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFD, LAT);  wait_idle();
        go(2'b10, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFF, LAT);  wait_idle();
        go(2'b10, 32'd7, 32'hFFFF_FFFE, 1, 32'd1, LAT);          wait_idle();

        // Divide by zero
        go(2'b00, 32'd5, 32'd0, 1, 32'hFFFF_FFFF, LAT_SPECIAL);  wait_idle();
        go(2'b10, 32'd5, 32'd0, 1, 32'd5, LAT_SPECIAL);          wait_idle();

        // Flush mid-RUN: no DONE, RESULT keeps 5
        go(2'b01, 32'd100, 32'd7, 0, 32'd0, LAT);
        repeat (9) @(negedge clk);
        chk("busy_in_run", {31'd0, dif.BUSY}, 32'd1);
        dif.FLUSH = 1'b1;
        @(negedge clk);
        dif.FLUSH = 1'b0;
        chk("flush_busy",   {31'd0, dif.BUSY}, 32'd0);
        chk("flush_result", dif.RESULT, 32'd5);
        repeat (40) @(negedge clk);
        chk("flush_result_held", dif.RESULT, 32'd5);

        // START while busy is ignored
        go(2'b01, 32'd100, 32'd7, 1, 32'd14, LAT);
        repeat (5) @(negedge clk);
        go(2'b01, 32'd50, 32'd5, 0, 32'd0, LAT);
        wait_idle();

        // Asynchronous reset mid-RUN
        go(2'b01, 32'd100, 32'd7, 0, 32'd0, LAT);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("areset_busy",   {31'd0, dif.BUSY}, 32'd0);
        chk("areset_done",   {31'd0, dif.DONE}, 32'd0);
        chk("areset_result", dif.RESULT,        32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        go(2'b01, 32'd9, 32'd3, 1, 32'd3, LAT);                  wait_idle();

        // Signed overflow
        go(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, LAT_SPECIAL); wait_idle();
        go(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0, LAT_SPECIAL);         wait_idle();

        // Back-to-back: new START in the DONE cycle
        go(2'b00, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFD, LAT);
        begin
            int n;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!dif.DONE && n < 100);
            if (dif.DONE) begin
                drive_now(2'b01, 32'hFFFF_FFFF, 32'd1, 1, 32'hFFFF_FFFF, LAT);
                @(negedge clk);
                dif.START = 1'b0;
                chk("b2b_busy",       {31'd0, dif.BUSY}, 32'd1);
                chk("b2b_result_old", dif.RESULT, 32'hFFFF_FFFD);
            end else begin
                n_total++;
                $display("FAIL b2b_first_done actual=none required=DONE");
            end
        end
        wait_idle();

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
